irq_pending_dispatcher: RTL and testbench

- Captures rising edges on 8 request lines into a sticky pending register and applies a per-line enable mask.
- Picks the lowest-numbered pending, enabled line; bit 0 has the highest priority, the same ordering as the team's 8-bit priority encoder.
- Presents the chosen index to a downstream consumer over a valid/ready handshake and clears that pending bit when the index is accepted.
- Sits between raw event sources and the interrupt/service logic.

---
 rtl/irq_pending_dispatcher.sv | 125 ++++++++++++
 tb/tb_irq_pending_dispatcher.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_dispatcher.sv
// ---------------------------------------------------------------------------
// IrqPendingDispatcher
//
// Purpose:
//   Latches rising edges on N_REQ request lines into a sticky pending
//   register, picks the lowest-numbered pending line that is also enabled
//   by the mask, and hands its index to a consumer over a valid/ready
//   handshake. The pending bit is cleared when the index is accepted.
//   Events that hit an already-pending line are lost and counted in a
//   saturating drop counter (one count per cycle with any loss).
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   req_in     - level request lines, a 0->1 transition is one event
//   mask_in    - 1 = line may be dispatched (masked lines still latch)
//   irq_valid  - registered, irq_idx holds a presented index
//   irq_idx    - registered index of the presented line
//   irq_ready  - consumer accepts; transfer on irq_valid & irq_ready
//   pending    - registered view of the pending register
//   drop_count - saturating count of cycles in which an event was lost
// ---------------------------------------------------------------------------
module irq_pending_dispatcher #(
    parameter int N_REQ  = 8,
    parameter int IDX_W  = 3,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req_in,
    input  logic [N_REQ-1:0]  mask_in,
    output logic              irq_valid,
    output logic [IDX_W-1:0]  irq_idx,
    input  logic              irq_ready,
    output logic [N_REQ-1:0]  pending,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic {
        IDLE,
        PRESENT
    } stateT;

    stateT             stateQ, stateD;
    logic [N_REQ-1:0]  reqQ;
    logic [N_REQ-1:0]  pendingQ, pendingD;
    logic [IDX_W-1:0]  idxQ, idxD;
    logic [DROP_W-1:0] dropQ, dropD;

    logic [N_REQ-1:0]  rise;
    logic [N_REQ-1:0]  clr;
    logic [N_REQ-1:0]  elig;
    logic [IDX_W-1:0]  firstIdx;
    logic              acc;
    logic              dropAny;

    assign irq_valid  = (stateQ == PRESENT);
    assign irq_idx    = idxQ;
    assign pending    = pendingQ;
    assign drop_count = dropQ;

    assign rise = req_in & ~reqQ;
    assign acc  = irq_valid & irq_ready;
    assign elig = pendingQ & mask_in;

    // One-hot clear of the presented line on the accepting cycle. A rise on
    // the same bit wins, since it is a fresh event rather than a loss.
    always_comb begin
        clr = '0;
        if (acc) begin
            clr[idxQ] = 1'b1;
        end
        pendingD = (pendingQ & ~clr) | rise;
        dropAny  = |(rise & pendingQ & ~clr);
        dropD    = (dropAny && (dropQ != {DROP_W{1'b1}})) ? dropQ + 1'b1 : dropQ;
    end

    // Lowest set bit of the eligible set; scanning downward lets bit 0 win.
    always_comb begin
        firstIdx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                firstIdx = IDX_W'(i);
            end
        end
    end

    // State register plus the datapath registers. During reset the request
    // history loads the live lines so anything held high creates no event.
    always_ff @(posedge clk) begin
        reqQ <= req_in;
        if (reset) begin
            stateQ   <= IDLE;
            pendingQ <= '0;
            idxQ     <= '0;
            dropQ    <= '0;
        end else begin
            stateQ   <= stateD;
            pendingQ <= pendingD;
            idxQ     <= idxD;
            dropQ    <= dropD;
        end
    end

    // Next-state logic: present as soon as anything is eligible, and stay
    // presenting until the consumer takes it, regardless of mask changes.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE:    if (|elig) stateD = PRESENT;
            PRESENT: if (acc)   stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Output logic: the index is only loaded when leaving IDLE, so it is
    // frozen during presentation and keeps its last value afterwards.
    always_comb begin
        idxD = idxQ;
        if ((stateQ == IDLE) && (|elig)) begin
            idxD = firstIdx;
        end
    end

endmodule

// File: tb/tb_irq_pending_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_irq_pending_dispatcher
//
// Drives directed scenarios and a randomized phase into the dispatcher and
// compares every cycle against a per-line event model kept in plain arrays.
// ---------------------------------------------------------------------------
module tb_irq_pending_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req_in;
    logic [7:0] mask_in;
    logic       irq_valid;
    logic [2:0] irq_idx;
    logic       irq_ready;
    logic [7:0] pending;
    logic [7:0] drop_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-line bits, a "busy presenting" flag, an index and
    // a plain integer loss counter.
    bit mPend[8];
    bit mPrev[8];
    bit mBusy;
    int mIdx;
    int mDrops;

    int dispatched[$];

    irq_pending_dispatcher #(.N_REQ(8), .IDX_W(3), .DROP_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .mask_in   (mask_in),
        .irq_valid (irq_valid),
        .irq_idx   (irq_idx),
        .irq_ready (irq_ready),
        .pending   (pending),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] modelPending();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = mPend[i];
        return v;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic modelStep(input logic [7:0] r, input logic [7:0] m, input logic rdy, input logic rst);
        bit oldPend[8];
        bit taken;
        bit lost;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mPend[i] = 0;
                mPrev[i] = r[i];
            end
            mBusy  = 0;
            mIdx   = 0;
            mDrops = 0;
            return;
        end
        oldPend = mPend;
        taken   = mBusy && rdy;
        lost    = 0;
        for (int i = 0; i < 8; i++) begin
            bit ev;
            bit gone;
            ev   = r[i] && !mPrev[i];
            gone = taken && (i == mIdx);
            if (ev && oldPend[i] && !gone) lost = 1;
            mPend[i] = (oldPend[i] && !gone) || ev;
            mPrev[i] = r[i];
        end
        if (lost && mDrops < 255) mDrops++;
        if (!mBusy) begin
            for (int i = 0; i < 8; i++) begin
                if (oldPend[i] && m[i]) begin
                    mBusy = 1;
                    mIdx  = i;
                    break;
                end
            end
        end else if (taken) begin
            mBusy = 0;
        end
    endtask

    // One full cycle: drive at the falling edge, check 1 time unit after
    // the rising edge.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m, input logic rdy, input logic rst);
        @(negedge clk);
        reset     = rst;
        req_in    = r;
        mask_in   = m;
        irq_ready = rdy;
        if (!rst && irq_valid === 1'b1 && rdy) dispatched.push_back(int'(irq_idx));
        modelStep(r, m, rdy, rst);
        @(posedge clk);
        #1;
        checkOutput("valid",   32'(irq_valid),  32'(mBusy));
        checkOutput("idx",     32'(irq_idx),    32'(mIdx));
        checkOutput("pending", 32'(pending),    32'(modelPending()));
        checkOutput("drops",   32'(drop_count), 32'(mDrops));
    endtask

    task automatic doReset(input logic [7:0] r);
        applyStimulus(r, 8'hFF, 1'b0, 1'b1);
        applyStimulus(r, 8'hFF, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] m;

        // Lines held high through reset create no events.
        doReset(8'hFF);
        checkOutput("rstValid", 32'(irq_valid), 0);
        checkOutput("rstPend",  32'(pending),   0);
        for (int i = 0; i < 10; i++) applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);
        checkOutput("heldPend", 32'(pending), 0);
        applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h08, 8'hFF, 1'b0, 1'b0);
        checkOutput("pulse3Pend", 32'(pending), 32'h08);
        applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
        checkOutput("pulse3Valid", 32'(irq_valid), 1);
        checkOutput("pulse3Idx",   32'(irq_idx),   3);

        // Simultaneous events dispatched lowest-first.
        doReset(8'h00);
        dispatched.delete();
        applyStimulus(8'hA4, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
        checkOutput("orderCount", 32'(dispatched.size()), 3);
        if (dispatched.size() == 3) begin
            checkOutput("order0", 32'(dispatched[0]), 2);
            checkOutput("order1", 32'(dispatched[1]), 5);
            checkOutput("order2", 32'(dispatched[2]), 7);
        end
        checkOutput("orderPend", 32'(pending), 0);

        // Mask hides the higher-priority line until re-enabled.
        doReset(8'h00);
        applyStimulus(8'h44, 8'hFB, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(8'h00, 8'hFB, 1'b1, 1'b0);
        checkOutput("maskPend", 32'(pending), 32'h04);
        for (int i = 0; i < 4; i++) applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
        checkOutput("unmaskPend", 32'(pending), 0);

        // Backpressure holds the presented index despite a bit-0 event.
        doReset(8'h00);
        applyStimulus(8'h10, 8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h01, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
            checkOutput("holdIdx", 32'(irq_idx), 4);
        end
        applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
        applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
        checkOutput("nextValid", 32'(irq_valid), 1);
        checkOutput("nextIdx",   32'(irq_idx),   0);

        // Repeated events on a masked pending line are counted as drops.
        doReset(8'h00);
        applyStimulus(8'h02, 8'h00, 1'b1, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h02, 8'h00, 1'b1, 1'b0);
            applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("drop3", 32'(drop_count), 3);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'h02, 8'h00, 1'b1, 1'b0);
            applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("dropSat", 32'(drop_count), 255);

        // Rise on the presented bit in the accepting cycle re-arms it.
        doReset(8'h00);
        applyStimulus(8'h04, 8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h04, 8'hFF, 1'b1, 1'b0);
        checkOutput("sameCycPend", 32'(pending[2]), 1);
        checkOutput("sameCycDrop", 32'(drop_count), 0);
        applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
        checkOutput("reValid", 32'(irq_valid), 1);
        checkOutput("reIdx",   32'(irq_idx),   2);
        applyStimulus(8'h00, 8'hFF, 1'b0, 1'b1);
        checkOutput("midRstValid", 32'(irq_valid),  0);
        checkOutput("midRstIdx",   32'(irq_idx),    0);
        checkOutput("midRstPend",  32'(pending),    0);
        checkOutput("midRstDrop",  32'(drop_count), 0);

        // Randomized traffic against the model.
        r = 8'h00;
        m = 8'hFF;
        applyStimulus(r, m, 1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            r = r ^ (8'($urandom) & 8'($urandom));
            if ((i % 50) == 0) m = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            applyStimulus(r, m, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
